fir_ctrl: RTL and testbench

FIR_CTRL -- requirements
Module: fir_ctrl

---
 rtl/fir_ctrl.sv | 179 +++++++++++++++++
 tb/tb_fir_ctrl.sv | 377 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_ctrl.sv
// fir_ctrl: AXI-lite control/status front end for the FIR engine.
// Holds ap_ctrl and data_length, and arbitrates the tap RAM port between AXI-lite and the engine.
module fir_ctrl #(
    parameter int pADDR_WIDTH = 12,
    parameter int pDATA_WIDTH = 32,
    parameter int Tape_Num    = 11
) (
    input  logic                   axis_clk,
    input  logic                   axis_rst_n,
    input  logic                   awvalid,
    input  logic [pADDR_WIDTH-1:0] awaddr,
    output logic                   awready,
    input  logic                   wvalid,
    input  logic [pDATA_WIDTH-1:0] wdata,
    output logic                   wready,
    input  logic                   arvalid,
    input  logic [pADDR_WIDTH-1:0] araddr,
    output logic                   arready,
    output logic                   rvalid,
    input  logic                   rready,
    output logic [pDATA_WIDTH-1:0] rdata,
    output logic [3:0]             tap_WE,
    output logic                   tap_EN,
    output logic [pDATA_WIDTH-1:0] tap_Di,
    output logic [pADDR_WIDTH-1:0] tap_A,
    input  logic [pDATA_WIDTH-1:0] tap_Do,
    input  logic                   eng_tap_en,
    input  logic [3:0]             eng_tap_idx,
    input  logic                   eng_done,
    output logic                   start_pulse,
    output logic [31:0]            data_length
);

    typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

    localparam logic [pADDR_WIDTH-1:0] ADDR_CTRL = '0;
    localparam logic [pADDR_WIDTH-1:0] ADDR_LEN  = pADDR_WIDTH'(16);
    localparam logic [pADDR_WIDTH-1:0] TAP_BASE  = pADDR_WIDTH'(32);
    localparam logic [pADDR_WIDTH-1:0] TAP_END   = pADDR_WIDTH'(32 + 4 * Tape_Num);

    function automatic logic is_tap(input logic [pADDR_WIDTH-1:0] a);
        return (a >= TAP_BASE) && (a < TAP_END) && (a[1:0] == 2'b00);
    endfunction

    state_t                   state_q;
    logic                     awready_q;
    logic [pADDR_WIDTH-1:0]   aw_addr_q;
    logic [pDATA_WIDTH-1:0]   w_data_q;
    logic                     arready_q;
    logic [pADDR_WIDTH-1:0]   ar_addr_q;
    logic                     rvalid_q;
    logic                     rd_ram_q;
    logic [pDATA_WIDTH-1:0]   rdata_q;
    logic                     start_q;
    logic                     done_q;
    logic [31:0]              len_q;

    logic                     wr_fire;
    logic                     rd_take;
    logic                     rd_fire;
    logic                     idle_d;
    logic                     collide;
    logic                     start_req;
    logic                     wr_len;
    logic [pDATA_WIDTH-1:0]   rd_value_d;

    assign wr_fire   = awvalid && wvalid && !awready_q;
    assign rd_take   = arvalid && !arready_q && !rvalid_q;
    // The RAM stays AXI-owned next cycle if we remain idle or the engine finishes now;
    // a tap read colliding with a tap write then waits one cycle so the write lands first.
    assign idle_d    = (state_q == S_IDLE) || eng_done;
    assign collide   = wr_fire && idle_d && is_tap(awaddr) && is_tap(araddr);
    assign rd_fire   = rd_take && !collide;
    assign start_req = awready_q && (state_q == S_IDLE) && (aw_addr_q == ADDR_CTRL) && w_data_q[0];
    assign wr_len    = awready_q && (state_q == S_IDLE) && (aw_addr_q == ADDR_LEN);

    always_comb begin
        rd_value_d = '0;
        if (ar_addr_q == ADDR_CTRL) begin
            rd_value_d = pDATA_WIDTH'({(state_q == S_IDLE), done_q, start_q});
        end else if (ar_addr_q == ADDR_LEN) begin
            rd_value_d = pDATA_WIDTH'(len_q);
        end else if (is_tap(ar_addr_q) && (state_q == S_RUN)) begin
            rd_value_d = '1;
        end
    end

    always_comb begin
        tap_EN = 1'b0;
        tap_WE = 4'h0;
        tap_A  = '0;
        tap_Di = '0;
        if (state_q == S_RUN) begin
            tap_EN = eng_tap_en;
            tap_A  = pADDR_WIDTH'({eng_tap_idx, 2'b00});
        end else if (awready_q && is_tap(aw_addr_q)) begin
            tap_EN = 1'b1;
            tap_WE = 4'hF;
            tap_A  = aw_addr_q - TAP_BASE;
            tap_Di = w_data_q;
        end else if (arready_q && is_tap(ar_addr_q)) begin
            tap_EN = 1'b1;
            tap_A  = ar_addr_q - TAP_BASE;
        end
    end

    always_ff @(posedge axis_clk or negedge axis_rst_n) begin
        if (!axis_rst_n) begin
            state_q   <= S_IDLE;
            awready_q <= 1'b0;
            aw_addr_q <= '0;
            w_data_q  <= '0;
            arready_q <= 1'b0;
            ar_addr_q <= '0;
            rvalid_q  <= 1'b0;
            rd_ram_q  <= 1'b0;
            rdata_q   <= '0;
            start_q   <= 1'b0;
            done_q    <= 1'b0;
            len_q     <= '0;
        end else begin
            start_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start_req) begin
                        state_q <= S_RUN;
                        start_q <= 1'b1;
                        done_q  <= 1'b0;
                    end
                end
                S_RUN: begin
                    if (eng_done) begin
                        state_q <= S_IDLE;
                        done_q  <= 1'b1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase

            if (wr_len) begin
                len_q <= 32'(w_data_q);
            end

            awready_q <= wr_fire;
            if (wr_fire) begin
                aw_addr_q <= awaddr;
                w_data_q  <= wdata;
            end

            arready_q <= rd_fire;
            if (rd_fire) begin
                ar_addr_q <= araddr;
            end

            // RAM data arrives in the first rvalid cycle; freeze it so it holds until rready.
            if (rd_ram_q) begin
                rdata_q  <= tap_Do;
                rd_ram_q <= 1'b0;
            end
            if (rvalid_q && rready) begin
                rvalid_q <= 1'b0;
            end
            if (arready_q) begin
                rvalid_q <= 1'b1;
                rd_ram_q <= (state_q == S_IDLE) && is_tap(ar_addr_q);
                rdata_q  <= rd_value_d;
            end
        end
    end

    assign awready     = awready_q;
    assign wready      = awready_q;
    assign arready     = arready_q;
    assign rvalid      = rvalid_q;
    assign rdata       = rd_ram_q ? tap_Do : rdata_q;
    assign start_pulse = start_q;
    assign data_length = len_q;

endmodule

// File: tb/tb_fir_ctrl.sv
// Scoreboard bench for fir_ctrl: randomized AXI-lite traffic against a register-map model,
// with a monitor process popping expected read data whenever rvalid&rready is seen.
module tb_fir_ctrl;
    localparam int AW = 12;
    localparam int DW = 32;
    localparam int NT = 11;

    logic          axis_clk    = 1'b0;
    logic          axis_rst_n  = 1'b0;
    logic          awvalid     = 1'b0;
    logic [AW-1:0] awaddr      = '0;
    logic          awready;
    logic          wvalid      = 1'b0;
    logic [DW-1:0] wdata       = '0;
    logic          wready;
    logic          arvalid     = 1'b0;
    logic [AW-1:0] araddr      = '0;
    logic          arready;
    logic          rvalid;
    logic          rready      = 1'b1;
    logic [DW-1:0] rdata;
    logic [3:0]    tap_WE;
    logic          tap_EN;
    logic [DW-1:0] tap_Di;
    logic [AW-1:0] tap_A;
    logic [DW-1:0] tap_Do;
    logic          eng_tap_en  = 1'b0;
    logic [3:0]    eng_tap_idx = '0;
    logic          eng_done    = 1'b0;
    logic          start_pulse;
    logic [31:0]   data_length;

    fir_ctrl #(.pADDR_WIDTH(AW), .pDATA_WIDTH(DW), .Tape_Num(NT)) dut (
        .axis_clk(axis_clk), .axis_rst_n(axis_rst_n),
        .awvalid(awvalid), .awaddr(awaddr), .awready(awready),
        .wvalid(wvalid), .wdata(wdata), .wready(wready),
        .arvalid(arvalid), .araddr(araddr), .arready(arready),
        .rvalid(rvalid), .rready(rready), .rdata(rdata),
        .tap_WE(tap_WE), .tap_EN(tap_EN), .tap_Di(tap_Di), .tap_A(tap_A), .tap_Do(tap_Do),
        .eng_tap_en(eng_tap_en), .eng_tap_idx(eng_tap_idx), .eng_done(eng_done),
        .start_pulse(start_pulse), .data_length(data_length)
    );

    always #5 axis_clk = ~axis_clk;

    // Tap RAM: one-cycle read latency, contents untouched by reset.
    logic [DW-1:0] ram [0:1023];
    always @(posedge axis_clk) begin
        if (tap_EN) begin
            if (tap_WE == 4'hF) ram[tap_A[AW-1:2]] <= tap_Di;
            tap_Do <= ram[tap_A[AW-1:2]];
        end
    end

    // Register-map model
    logic [31:0] taps_m [0:NT-1];
    logic [31:0] len_m  = '0;
    bit          run_m  = 1'b0;
    bit          done_m = 1'b0;

    logic [31:0] sb_q [$];
    logic [11:0] sb_a [$];
    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int ar_cyc   = -100;
    logic prev_rvalid = 1'b0;
    int coef [0:NT-1] = '{0, -10, -9, 23, 56, 63, 56, 23, -9, -10, 0};

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic bit is_tap_m(input logic [11:0] a);
        int ia = int'(a);
        return (ia >= 32) && (ia < 32 + 4 * NT) && (ia % 4 == 0);
    endfunction

    function automatic logic [31:0] exp_rd(input logic [11:0] a);
        int ia = int'(a);
        if (ia == 0)       return {29'd0, !run_m, done_m, 1'b0};
        if (ia == 16)      return len_m;
        if (is_tap_m(a))   return run_m ? 32'hFFFF_FFFF : taps_m[(ia - 32) / 4];
        return 32'd0;
    endfunction

    function automatic void model_write(input logic [11:0] a, input logic [31:0] d);
        int ia = int'(a);
        if (run_m) return;
        if (ia == 0) begin
            if (d[0]) begin
                run_m  = 1'b1;
                done_m = 1'b0;
            end
        end else if (ia == 16) begin
            len_m = d;
        end else if (is_tap_m(a)) begin
            taps_m[(ia - 32) / 4] = d;
        end
    endfunction

    always @(posedge axis_clk) cyc <= cyc + 1;

    // Monitor: pops the scoreboard on every completed read
    always @(negedge axis_clk) begin
        if (arready) ar_cyc = cyc;
        if (rvalid && !prev_rvalid) check("rvalid_after_arready", 64'(cyc - ar_cyc), 64'd1);
        if (rvalid && rready) begin
            if (sb_q.size() == 0) begin
                check("unexpected_rvalid", 64'd1, 64'd0);
            end else begin
                logic [31:0] e;
                logic [11:0] a;
                e = sb_q.pop_front();
                a = sb_a.pop_front();
                $display("rd addr=%03h data=%08h", a, rdata);
                check($sformatf("rdata@%03h", a), 64'(rdata), 64'(e));
            end
        end
        prev_rvalid = rvalid;
    end

    initial begin
        forever begin
            @(posedge axis_clk);
            #1;
            rready = ($urandom_range(0, 3) != 0);
        end
    end

    task automatic axi_write(input logic [11:0] a, input logic [31:0] d);
        bit got = 1'b0;
        bit pair_bad = 1'b0;
        int lat = 99;
        @(posedge axis_clk); #1;
        awvalid = 1'b1; wvalid = 1'b1; awaddr = a; wdata = d;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge axis_clk);
            if (awready !== wready) pair_bad = 1'b1;
            if (awready && wready) begin
                got = 1'b1;
                lat = i;
                if (run_m)
                    check("run_wr_tap_port", 64'({tap_EN, tap_WE}), 64'({eng_tap_en, 4'h0}));
                else if (is_tap_m(a))
                    check("idle_wr_tap_port", 64'({tap_EN, tap_WE, tap_A, tap_Di}),
                          64'({1'b1, 4'hF, a - 12'h020, d}));
                else
                    check("idle_wr_no_tap", 64'(tap_EN), 64'd0);
                if (int'(a) == 16) check("len_before_update", 64'(data_length), 64'(len_m));
            end
        end
        @(posedge axis_clk); #1;
        awvalid = 1'b0; wvalid = 1'b0;
        check("wr_ready_pair", 64'(pair_bad), 64'd0);
        check("wr_handshake_lat", 64'(lat), 64'd1);
        if (got) model_write(a, d);
        $display("wr addr=%03h data=%08h", a, d);
    endtask

    task automatic axi_read(input logic [11:0] a);
        bit got = 1'b0;
        int lat = 99;
        for (int i = 0; i < 50 && sb_q.size() != 0; i++) @(negedge axis_clk);
        sb_q.push_back(exp_rd(a));
        sb_a.push_back(a);
        @(posedge axis_clk); #1;
        arvalid = 1'b1; araddr = a;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge axis_clk);
            if (arready) begin
                got = 1'b1;
                lat = i;
                if (run_m)
                    check("run_rd_tap_port", 64'({tap_EN, tap_WE}), 64'({eng_tap_en, 4'h0}));
                else if (is_tap_m(a))
                    check("idle_rd_tap_port", 64'({tap_EN, tap_WE, tap_A}), 64'({1'b1, 4'h0, a - 12'h020}));
                else
                    check("idle_rd_no_tap", 64'(tap_EN), 64'd0);
            end
        end
        @(posedge axis_clk); #1;
        arvalid = 1'b0;
        check("rd_handshake_lat", 64'(lat), 64'd1);
        if (!got) begin
            void'(sb_q.pop_back());
            void'(sb_a.pop_back());
        end
    endtask

    task automatic eng_pulse();
        @(posedge axis_clk); #1; eng_done = 1'b1;
        @(posedge axis_clk); #1; eng_done = 1'b0;
        if (run_m) begin
            run_m  = 1'b0;
            done_m = 1'b1;
        end
        $display("eng_done pulse");
    endtask

    function automatic logic [11:0] rand_addr(input bit allow_ctrl);
        case ($urandom_range(0, 6))
            0, 6:    return 12'h010;
            1, 2:    return 12'(32 + 4 * $urandom_range(0, NT - 1));
            3:       return allow_ctrl ? 12'h000 : 12'h010;
            4:       return 12'h04C;
            default: begin
                logic [11:0] um [0:4];
                um = '{12'h004, 12'h014, 12'h022, 12'h100, 12'h050};
                return um[$urandom_range(0, 4)];
            end
        endcase
    endfunction

    initial begin
        logic [11:0] a;
        logic [31:0] d;
        bit got;

        repeat (3) @(posedge axis_clk);
        #1;
        check("rst_ctrl_outs", 64'({awready, wready, arready, rvalid, start_pulse, tap_EN, tap_WE}), 64'd0);
        check("rst_tap_outs", 64'({tap_A, tap_Di}), 64'd0);
        check("rst_rdata_len", 64'({rdata, data_length}), 64'd0);
        @(posedge axis_clk); #1;
        axis_rst_n = 1'b1;
        for (int k = 0; k < NT; k++) taps_m[k] = 32'd0;
        for (int k = 0; k < NT; k++) ram[k] = 32'd0;

        axi_read(12'h000);

        // Unmapped / out-of-range taps / read-only ctrl bits
        axi_write(12'h04C, 32'd123);
        axi_write(12'h060, 32'd77);
        axi_write(12'h000, 32'h6);
        axi_read(12'h04C);
        axi_read(12'h060);
        axi_read(12'h000);
        axi_read(12'h004);

        // Randomized IDLE traffic
        repeat (40) begin
            a = rand_addr(1'b1);
            d = $urandom;
            if (a == 12'h000) d[0] = 1'b0;
            if ($urandom_range(0, 1) == 1) axi_write(a, d);
            else                           axi_read(a);
        end

        // Program and read back the reference taps
        for (int k = 0; k < NT; k++) axi_write(12'(32 + 4 * k), 32'(coef[k]));
        for (int k = 0; k < NT; k++) axi_read(12'(32 + 4 * k));

        // IDLE: engine tap enable must not reach the RAM
        @(posedge axis_clk); #1; eng_tap_en = 1'b1; eng_tap_idx = 4'd5;
        @(negedge axis_clk);
        check("idle_eng_ignored", 64'(tap_EN), 64'd0);
        @(posedge axis_clk); #1; eng_tap_en = 1'b0;

        // Start
        axi_write(12'h010, 32'd600);
        axi_write(12'h000, 32'd1);
        @(negedge axis_clk);
        check("start_pulse_hi", 64'(start_pulse), 64'd1);
        @(negedge axis_clk);
        check("start_pulse_lo", 64'(start_pulse), 64'd0);
        check("data_length", 64'(data_length), 64'd600);
        axi_read(12'h000);

        // RUN: engine owns the RAM
        @(posedge axis_clk); #1; eng_tap_en = 1'b1; eng_tap_idx = 4'd5;
        @(negedge axis_clk);
        check("run_eng_tap_port", 64'({tap_EN, tap_WE, tap_A}), 64'({1'b1, 4'h0, 12'd20}));
        @(posedge axis_clk); #1; eng_tap_en = 1'b0;

        axi_write(12'h024, 32'd99);
        axi_read(12'h024);
        axi_write(12'h010, 32'd5);
        axi_read(12'h010);
        repeat (12) begin
            a = rand_addr(1'b1);
            d = $urandom;
            if ($urandom_range(0, 1) == 1) axi_write(a, d);
            else                           axi_read(a);
        end

        eng_pulse();
        axi_read(12'h000);
        axi_read(12'h000);
        axi_read(12'h024);
        axi_read(12'h010);
        eng_pulse();
        axi_read(12'h000);

        // Restart clears done, then finish again
        axi_write(12'h000, 32'd1);
        axi_read(12'h000);
        eng_pulse();
        axi_read(12'h000);

        // Simultaneous tap write and tap read: write lands first
        begin : collide_blk
            int aw_lat;
            int ar_lat;
            for (int i = 0; i < 50 && sb_q.size() != 0; i++) @(negedge axis_clk);
            taps_m[2] = 32'h1234_5678;
            sb_q.push_back(32'h1234_5678);
            sb_a.push_back(12'h028);
            aw_lat = 99;
            ar_lat = 99;
            @(posedge axis_clk); #1;
            awvalid = 1'b1; wvalid = 1'b1; awaddr = 12'h028; wdata = 32'h1234_5678;
            arvalid = 1'b1; araddr = 12'h028;
            for (int i = 0; i < 20 && (awvalid || arvalid); i++) begin
                @(negedge axis_clk);
                if (awvalid && awready && wready) aw_lat = i;
                if (arvalid && arready) ar_lat = i;
                @(posedge axis_clk); #1;
                if (aw_lat == i) begin awvalid = 1'b0; wvalid = 1'b0; end
                if (ar_lat == i) arvalid = 1'b0;
            end
            awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
            $display("collide wr/rd addr=028 aw_lat=%0d ar_lat=%0d", aw_lat, ar_lat);
            check("collide_wr_lat", 64'(aw_lat), 64'd1);
            check("collide_rd_lat", 64'(ar_lat), 64'd2);
            if (ar_lat == 99) begin
                void'(sb_q.pop_back());
                void'(sb_a.pop_back());
            end
        end

        // Reset mid-RUN with a read in flight
        axi_write(12'h000, 32'd1);
        for (int i = 0; i < 50 && sb_q.size() != 0; i++) @(negedge axis_clk);
        @(posedge axis_clk); #1;
        arvalid = 1'b1; araddr = 12'h000;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge axis_clk);
            if (arready) got = 1'b1;
        end
        check("inflight_rd_accept", 64'(got), 64'd1);
        #1;
        axis_rst_n = 1'b0;
        arvalid = 1'b0;
        #1;
        check("arst_ctrl_outs", 64'({awready, wready, arready, rvalid, start_pulse, tap_EN, tap_WE}), 64'd0);
        check("arst_tap_outs", 64'({tap_A, tap_Di}), 64'd0);
        check("arst_rdata_len", 64'({rdata, data_length}), 64'd0);
        run_m = 1'b0; done_m = 1'b0; len_m = '0;
        repeat (3) @(posedge axis_clk);
        @(negedge axis_clk);
        check("inflight_rd_dropped", 64'(rvalid), 64'd0);
        @(posedge axis_clk); #1;
        axis_rst_n = 1'b1;
        $display("reset released");
        axi_read(12'h000);
        axi_read(12'h010);
        for (int k = 0; k < NT; k++) axi_read(12'(32 + 4 * k));

        for (int i = 0; i < 100 && sb_q.size() != 0; i++) @(negedge axis_clk);
        check("sb_drain", 64'(sb_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

endmodule
